seq_stage_controller: RTL and testbench
=======================================

Name: seq_stage_controller

Overview:
Multi-cycle sequencer for the Y86-64 SEQ datapath. It steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update, issuing one-cycle stage enables. It gates condition-code updates for the execute/ALU stage and handshakes with data memory. It tracks processor status (AOK/HLT/ADR/INS) and retired-instruction and cycle counters.

Parameters:
MEM_TIMEOUT, 15, max cycles MEMORY waits for mem_ack before raising ADR (valid range 1..255)
CNT_W, 32, width of instr_count and cycle_count

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin execution; sampled only in IDLE
icode  input  4  instruction code from fetch logic; sampled in FETCH
instr_valid  input  1  fetch decoded a legal instruction; sampled in FETCH
imem_error  input  1  instruction-memory address error; sampled in FETCH
mem_ack  input  1  data memory completed the access
dmem_error  input  1  data-memory address error; qualified by mem_ack
fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en  output  1 each  one-hot stage enables
cc_we  output  1  condition-code register write enable
mem_req  output  1  data memory request, held until ack or timeout
stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
running  output  1  high in every state except IDLE and DONE
instr_count  output  CNT_W  instructions retired since start
cycle_count  output  CNT_W  cycles spent running since start

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Reset, at any time including mid-instruction or mid-handshake: state=IDLE; all enables, cc_we and mem_req = 0; stat=1; counters=0; in-flight access abandoned.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, DONE. Each stage enable is high only in its own state. All outputs are registered or decoded from state; there is no input-to-output combinational path.
- IDLE:
  - start=1 -> FETCH; same edge clears both counters and sets stat=1.
- FETCH: icode is latched into an internal register. Checks apply in priority order:
  1. imem_error -> stat=3, DONE.
  2. !instr_valid or icode>4'hB -> stat=4, DONE.
  3. icode==4'h0 (halt) -> stat=2, instr_count+1, DONE.
  4. Otherwise -> DECODE.
- DECODE -> EXECUTE: 1 cycle.
- EXECUTE -> MEMORY: 1 cycle.
  - cc_we=1 only when the latched icode==4'h6 (OPq).
  - cmovxx, jXX and all other icodes never write CC.
- MEMORY, for memory icodes {4,5,8,9,A,B}:
  - mem_req=1 from the first MEMORY cycle. mem_ack sampled in the same cycle counts.
  - On ack with dmem_error=0 -> WRITEBACK.
  - On ack with dmem_error=1 -> stat=3, DONE; WRITEBACK and PCUPD are skipped.
  - Wait counter starts at 0 on entry and increments each cycle without ack. Reaching MEM_TIMEOUT -> stat=3, DONE; mem_req drops.
- MEMORY, for non-memory icodes: 1 cycle, mem_req=0.
- WRITEBACK -> PCUPD: 1 cycle.
- PCUPD -> FETCH: instr_count increments on this transition.
- Latency: a non-memory instruction takes 6 cycles FETCH-to-FETCH. A memory instruction acked k cycles after the MEMORY entry cycle takes 6+k.
- cycle_count increments every cycle running=1. Both counters wrap modulo 2^CNT_W silently.
- DONE: held until reset; start ignored; stat and counters frozen.
- stat changes only at the DONE-entry edge and at start.

Test Plan:
- Reset 3 cycles, start=1 for one cycle, icode=6 then 0 (OPq, halt) -> enables walk F,D,E,M,W,P with cc_we high only in EXECUTE; halt -> DONE, stat=2, instr_count=2, cycle_count=7, mem_req never high.
- icode=5 (mrmovq), mem_ack after 3 wait cycles, dmem_error=0 -> mem_req high for 4 cycles; instruction takes 9 cycles; instr_count=1 at the next FETCH; cc_we never high.
- icode=A (pushq), mem_ack never asserted, MEM_TIMEOUT=15 -> mem_req high exactly 15 cycles, then DONE, stat=3; wb_en and pc_en never pulse.
- icode=4, mem_ack=1 with dmem_error=1 on the first MEMORY cycle -> DONE next cycle, stat=3, instr_count unchanged.
- FETCH with imem_error=1 and instr_valid=0 together -> stat=3, since ADR has priority. Separately, icode=4'hC -> stat=4.
- Assert reset during MEMORY with mem_req=1 -> next cycle IDLE, mem_req=0, stat=1, counters 0; start reruns normally. Also: start pulsed while in DONE -> no effect.

Source files
------------

// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ datapath: walks each instruction through
// fetch..PC-update, gates CC writes, handshakes with data memory and tracks status/counters.
module seq_stage_controller #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             mem_ack,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             cc_we,
    output logic             mem_req,
    output logic [2:0]       stat,
    output logic             running,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StMemory,
        StWriteback,
        StPcupd,
        StDone
    } state_e;

    localparam logic [2:0] StatAok  = 3'd1;
    localparam logic [2:0] StatHlt  = 3'd2;
    localparam logic [2:0] StatAdr  = 3'd3;
    localparam logic [2:0] StatIns  = 3'd4;
    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e           state_q;
    logic [3:0]       icode_q;
    logic [7:0]       wait_q;
    logic [2:0]       stat_q;
    logic [CNT_W-1:0] instr_q;
    logic [CNT_W-1:0] cycle_q;
    logic             is_mem_op;

    assign is_mem_op = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            icode_q <= '0;
            wait_q  <= '0;
            stat_q  <= StatAok;
            instr_q <= '0;
            cycle_q <= '0;
        end else begin
            if (running) begin
                cycle_q <= cycle_q + 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StFetch;
                        stat_q  <= StatAok;
                        instr_q <= '0;
                        cycle_q <= '0;
                    end
                end
                StFetch: begin
                    icode_q <= icode;
                    if (imem_error) begin
                        stat_q  <= StatAdr;
                        state_q <= StDone;
                    end else if (!instr_valid || icode > 4'hB) begin
                        stat_q  <= StatIns;
                        state_q <= StDone;
                    end else if (icode == 4'h0) begin
                        // halt retires as an instruction
                        stat_q  <= StatHlt;
                        instr_q <= instr_q + 1'b1;
                        state_q <= StDone;
                    end else begin
                        state_q <= StDecode;
                    end
                end
                StDecode: state_q <= StExecute;
                StExecute: begin
                    state_q <= StMemory;
                    wait_q  <= '0;
                end
                StMemory: begin
                    if (!is_mem_op) begin
                        state_q <= StWriteback;
                    end else if (mem_ack) begin
                        if (dmem_error) begin
                            stat_q  <= StatAdr;
                            state_q <= StDone;
                        end else begin
                            state_q <= StWriteback;
                        end
                    end else if (wait_q == WaitLast) begin
                        stat_q  <= StatAdr;
                        state_q <= StDone;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StWriteback: state_q <= StPcupd;
                StPcupd: begin
                    state_q <= StFetch;
                    instr_q <= instr_q + 1'b1;
                end
                StDone: state_q <= StDone;
            endcase
        end
    end

    assign fetch_en    = (state_q == StFetch);
    assign decode_en   = (state_q == StDecode);
    assign execute_en  = (state_q == StExecute);
    assign memory_en   = (state_q == StMemory);
    assign wb_en       = (state_q == StWriteback);
    assign pc_en       = (state_q == StPcupd);
    assign cc_we       = (state_q == StExecute) && (icode_q == 4'h6);
    assign mem_req     = (state_q == StMemory) && is_mem_op;
    assign running     = (state_q != StIdle) && (state_q != StDone);
    assign stat        = stat_q;
    assign instr_count = instr_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Bench for seq_stage_controller: programs are expanded into an expected per-cycle stage
// timeline from the instruction-level rules, then replayed against the DUT cycle by cycle.
module tb_seq_stage_controller;

    localparam int MT = 15;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_error;
    logic        mem_ack;
    logic        dmem_error;
    logic        fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en;
    logic        cc_we;
    logic        mem_req;
    logic [2:0]  stat;
    logic        running;
    logic [31:0] instr_count;
    logic [31:0] cycle_count;

    seq_stage_controller #(
        .MEM_TIMEOUT(MT),
        .CNT_W      (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .icode      (icode),
        .instr_valid(instr_valid),
        .imem_error (imem_error),
        .mem_ack    (mem_ack),
        .dmem_error (dmem_error),
        .fetch_en   (fetch_en),
        .decode_en  (decode_en),
        .execute_en (execute_en),
        .memory_en  (memory_en),
        .wb_en      (wb_en),
        .pc_en      (pc_en),
        .cc_we      (cc_we),
        .mem_req    (mem_req),
        .stat       (stat),
        .running    (running),
        .instr_count(instr_count),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stage numbering for the model: 0 idle, 1..6 = F,D,E,M,W,P, 7 done
    typedef struct {
        logic [3:0] icode;
        bit         valid;
        bit         ierr;
        int         k;      // MEMORY cycles before ack; >= MT means never acked
        bit         derr;
    } ins_t;

    typedef struct {
        int         stage;
        bit         cc;
        bit         mreq;
        logic [3:0] icode;
        bit         valid;
        bit         ierr;
        bit         ack;
        bit         derr;
        int         instr;
        int         cyc;
    } ent_t;

    ins_t prog[$];
    ent_t tl[$];
    int   m_instr, m_cyc;
    int   f_stat, f_instr, f_cyc;
    int   errors = 0;
    int   checks = 0;

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    function automatic ins_t mk(logic [3:0] ic, bit v, bit ie, int k, bit de);
        ins_t p;
        p.icode = ic; p.valid = v; p.ierr = ie; p.k = k; p.derr = de;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input int stage, input bit cc, input bit mreq, input int st,
                               input int ni, input int nc);
        logic [5:0] exp_en;
        exp_en = (stage >= 1 && stage <= 6) ? (6'b100000 >> (stage - 1)) : 6'b0;
        chk("enables", {fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en}, exp_en);
        chk("cc_we", cc_we, cc);
        chk("mem_req", mem_req, mreq);
        chk("running", running, (stage >= 1 && stage <= 6));
        chk("stat", stat, st);
        chk("instr_count", instr_count, ni);
        chk("cycle_count", cycle_count, nc);
    endtask

    task automatic add(input int stage, input bit cc, input bit mreq, input bit ack,
                       input bit derr);
        ent_t e;
        e.stage = stage; e.cc = cc; e.mreq = mreq; e.ack = ack; e.derr = derr;
        e.icode = 4'($urandom); e.valid = rb(); e.ierr = rb();
        e.instr = m_instr; e.cyc = m_cyc;
        tl.push_back(e);
        m_cyc++;
    endtask

    task automatic fin(input int s);
        f_stat = s; f_instr = m_instr; f_cyc = m_cyc;
    endtask

    // Expand the program into the cycle-by-cycle timeline the rules imply
    task automatic build();
        ins_t p;
        int   last;
        bit   mem_op;
        tl.delete();
        m_instr = 0; m_cyc = 0;
        f_stat = 0; f_instr = 0; f_cyc = 0;
        foreach (prog[i]) begin
            p = prog[i];
            add(1, 0, 0, rb(), rb());
            last = tl.size() - 1;
            tl[last].icode = p.icode;
            tl[last].valid = p.valid;
            tl[last].ierr  = p.ierr;
            if (p.ierr) begin fin(3); return; end
            if (!p.valid || p.icode > 4'hB) begin fin(4); return; end
            if (p.icode == 4'h0) begin m_instr++; fin(2); return; end
            add(2, 0, 0, rb(), rb());
            add(3, p.icode == 4'h6, 0, rb(), rb());
            mem_op = p.icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
            if (!mem_op) begin
                add(4, 0, 0, rb(), rb());
            end else if (p.k >= MT) begin
                for (int j = 0; j < MT; j++) add(4, 0, 1, 0, rb());
                fin(3);
                return;
            end else begin
                for (int j = 0; j < p.k; j++) add(4, 0, 1, 0, rb());
                add(4, 0, 1, 1, p.derr);
                if (p.derr) begin fin(3); return; end
            end
            add(5, 0, 0, rb(), rb());
            add(6, 0, 0, rb(), rb());
            m_instr++;
        end
    endtask

    task automatic begin_run();
        @(negedge clk);
        reset = 1'b1; start = rb(); icode = 4'($urandom);
        mem_ack = rb(); dmem_error = rb(); instr_valid = rb(); imem_error = rb();
        @(negedge clk);
        check_cycle(0, 0, 0, 1, 0, 0);
        repeat (2) @(negedge clk);
        check_cycle(0, 0, 0, 1, 0, 0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check_cycle(0, 0, 0, 1, 0, 0);
        start = 1'b1;
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n && i < tl.size(); i++) begin
            @(negedge clk);
            start       = rb();
            icode       = tl[i].icode;
            instr_valid = tl[i].valid;
            imem_error  = tl[i].ierr;
            mem_ack     = tl[i].ack;
            dmem_error  = tl[i].derr;
            check_cycle(tl[i].stage, tl[i].cc, tl[i].mreq, 1, tl[i].instr, tl[i].cyc);
        end
    endtask

    task automatic check_done();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = (i == 0) ? 1'b1 : rb();
            mem_ack = rb(); dmem_error = rb(); icode = 4'($urandom);
            check_cycle(7, 0, 0, f_stat, f_instr, f_cyc);
        end
    endtask

    task automatic run_full();
        build();
        begin_run();
        play(tl.size());
        check_done();
    endtask

    task automatic gen_random();
        int         n;
        int         k;
        logic [3:0] ic;
        logic [3:0] memops [6];
        memops = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        n = $urandom_range(1, 6);
        prog.delete();
        for (int i = 0; i < n; i++) begin
            ic = 4'($urandom_range(1, 11));
            k  = ($urandom_range(0, 5) == 0) ? MT - 1 : $urandom_range(0, 4);
            prog.push_back(mk(ic, 1, 0, k, 0));
        end
        case ($urandom_range(0, 5))
            0: prog.push_back(mk(4'h0, 1, 0, 0, 0));
            1: prog.push_back(mk(4'($urandom), rb(), 1, 0, 0));
            2: prog.push_back(mk(4'($urandom_range(0, 11)), 0, 0, 0, 0));
            3: prog.push_back(mk(4'($urandom_range(12, 15)), 1, 0, 0, 0));
            4: prog.push_back(mk(memops[$urandom_range(0, 5)], 1, 0, $urandom_range(0, 4), 1));
            default: prog.push_back(mk(memops[$urandom_range(0, 5)], 1, 0, 99, 0));
        endcase
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; icode = 4'h0; instr_valid = 1'b0;
        imem_error = 1'b0; mem_ack = 1'b0; dmem_error = 1'b0;

        // OPq then halt
        prog = '{mk(4'h6, 1, 0, 0, 0), mk(4'h0, 1, 0, 0, 0)};
        run_full();
        // mrmovq acked after 3 wait cycles, then halt
        prog = '{mk(4'h5, 1, 0, 3, 0), mk(4'h0, 1, 0, 0, 0)};
        run_full();
        // pushq never acked: timeout
        prog = '{mk(4'hA, 1, 0, 99, 0)};
        run_full();
        // rmmovq acked with data error on first MEMORY cycle
        prog = '{mk(4'h4, 1, 0, 0, 1)};
        run_full();
        // imem_error beats invalid instruction
        prog = '{mk(4'h3, 0, 1, 0, 0)};
        run_full();
        // icode beyond 0xB
        prog = '{mk(4'hC, 1, 0, 0, 0)};
        run_full();
        // nop then pushq, reset while the memory request is outstanding
        prog = '{mk(4'h1, 1, 0, 0, 0), mk(4'hA, 1, 0, 99, 0)};
        build();
        begin_run();
        play(12);
        prog = '{mk(4'h2, 1, 0, 0, 0), mk(4'h7, 1, 0, 0, 0), mk(4'h0, 1, 0, 0, 0)};
        run_full();

        for (int r = 0; r < 25; r++) begin
            gen_random();
            run_full();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
